disp_chan_sequencer: RTL

//  Drives the channel select (Test) and load enable (EN) of Multi_8CH32 in the display path.

---
 rtl/disp_chan_sequencer_pkg.sv | 16 +
 rtl/disp_chan_sequencer_rr_next_sel.sv | 33 +++
 rtl/disp_chan_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/disp_chan_sequencer_pkg.sv
// Shared state encoding and channel-select sizing for the display channel sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package disp_chan_sequencer_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_MANUAL = 2'd3
    } state_t;

endpackage

// File: rtl/disp_chan_sequencer_rr_next_sel.sv
// Round-robin pick of the first enabled channel strictly after cur (circular).
// Latency: combinational.
// Backpressure: none.
module rr_next_sel
    import disp_chan_sequencer_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrapped,
    output logic             none
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        none  = (mask == '0);
        // i == NCH lands back on cur, so a lone enabled channel reselects itself
        for (int i = 1; i <= NCH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrapped = !none && (nxt <= cur);
    end

endmodule

// File: rtl/disp_chan_sequencer.sv
// Display channel sequencer: auto round-robin scan with dwell, hold/step, or manual select.
// Latency: all outputs registered, 1 cycle from inputs.
// Backpressure: none; Multi_8CH32 must accept an EN load pulse every cycle.
module disp_chan_sequencer
    import disp_chan_sequencer_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_auto,
    input  logic [SEL_W-1:0]   man_sel,
    input  logic [NCH-1:0]     chan_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    input  logic               step,
    output logic [SEL_W-1:0]   Test,
    output logic               EN,
    output logic               scan_wrap,
    output logic               busy
);

    state_t             state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d, reload;
    logic [SEL_W-1:0]   test_d, rr_cur, rr_nxt;
    logic               en_d, wrap_d, rr_wrapped, rr_none;

    // From IDLE, searching after the top channel yields the first enabled channel from 0
    assign rr_cur = (state == ST_IDLE) ? SEL_W'(NCH - 1) : Test;
    assign reload = (dwell == '0) ? '0 : dwell - 1'b1;

    rr_next_sel u_rr (
        .cur     (rr_cur),
        .mask    (chan_en),
        .nxt     (rr_nxt),
        .wrapped (rr_wrapped),
        .none    (rr_none)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        test_d  = Test;
        en_d    = 1'b0;
        wrap_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mode_auto) begin
                    state_d = ST_MANUAL;
                    test_d  = man_sel;
                    en_d    = 1'b1;
                end else if (!rr_none) begin
                    state_d = ST_SCAN;
                    test_d  = rr_nxt;
                    cnt_d   = reload;
                    en_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!mode_auto) begin
                    state_d = ST_MANUAL;
                    test_d  = man_sel;
                    en_d    = 1'b1;
                end else if (rr_none) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_HOLD;
                end else if (cnt == '0 || step || !chan_en[Test]) begin
                    // a disabled current channel is treated like dwell expiry
                    test_d = rr_nxt;
                    cnt_d  = reload;
                    en_d   = 1'b1;
                    wrap_d = rr_wrapped;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (!mode_auto) begin
                    state_d = ST_MANUAL;
                    test_d  = man_sel;
                    en_d    = 1'b1;
                end else if (rr_none) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    state_d = ST_SCAN;
                end
            end
            ST_MANUAL: begin
                if (mode_auto) begin
                    state_d = ST_IDLE;
                end else begin
                    test_d = man_sel;
                    en_d   = (man_sel != Test);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            Test      <= '0;
            EN        <= 1'b0;
            scan_wrap <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            Test      <= test_d;
            EN        <= en_d;
            scan_wrap <= wrap_d;
            busy      <= (state_d == ST_SCAN) || (state_d == ST_HOLD);
        end
    end

endmodule
